countdown_timer_chain: RTL and testbench
========================================

Name: countdown_timer_chain

Overview:
Parametrised multi-digit BCD countdown timer, generalising the single mod-6 digit counter into a chain of NUM_DIGITS digits, each with its own modulus. It adds a run-control state machine (idle/run/pause/done), load clamping and a one-cycle expiry pulse. It sits between the 1 Hz tick generator and the seven-segment display and game-over logic. Default configuration is MM:SS (59:59 max).

Parameters:
NUM_DIGITS, 4, number of chained BCD digits; digit 0 is least significant.
MODULI, 16'h6A6A, packed NUM_DIGITS*4-bit vector; bits [4i+3:4i] give digit i's modulus (2..10). Default is digit0=10, digit1=6, digit2=10, digit3=6.

Ports:
clk  in  1  system clock
resetN  in  1  reset
tick  in  1  one-clk count strobe (ena); decrements only in RUN
start  in  1  one-clk pulse; start or resume
pause  in  1  one-clk pulse; pause
loadN  in  1  synchronous active-low load
datain  in  NUM_DIGITS*4  load value, BCD per digit
count  out  NUM_DIGITS*4  current value, BCD per digit
running  out  1  high while state==RUN
expired  out  1  registered one-clk pulse on reaching zero
zero  out  1  combinational; high when every digit is 0

Behaviour:
- Reset: resetN, asynchronous, active-low; clock clk.
  - Reset values: count=0, state=IDLE, running=0, expired=0.
  - Reset mid-run aborts immediately with no expired pulse.
- States:
  - IDLE -> RUN: on start with count!=0. start with count==0 is ignored.
  - RUN -> PAUSE: on pause.
  - PAUSE -> RUN: on start.
  - RUN -> DONE: on the decrementing tick that yields count==0.
  - DONE: holds until loadN (-> IDLE). start in DONE is ignored.
- Priority, highest first: loadN, then pause, then start, then tick.
  - loadN low in any state: count<=clamped datain, state<=IDLE, expired<=0.
  - pause and start in the same cycle: pause wins.
- Load clamping: any digit i with datain digit >= modulus_i loads modulus_i-1. No non-BCD value ever appears on count.
- Decrement, only when state==RUN and tick=1 and neither pause nor loadN is asserted:
  - Digit 0 always steps.
  - Digit i steps when all lower digits are 0 (borrow chain).
  - A stepping digit at 0 wraps to modulus_i-1; otherwise it decrements by 1.
  - Whole-chain underflow cannot occur, because RUN is left at zero.
- Latency:
  - count updates the clk after tick.
  - expired is high in that same following cycle, aligned with count first reading 0, for exactly one clk.
- tick in the start cycle is ignored, since the state is not yet RUN. tick in PAUSE, IDLE or DONE is ignored.
- running = (state==RUN), registered.

Optional Feature:
COUNTDOWN_AUTORELOAD_EN.
- Defined:
  - A reload register captures the clamped datain on every loadN.
  - On the zero-reaching tick, count<=reload value and state stays RUN; expired still pulses one clk.
  - If the reload value is 0, behaviour falls back to DONE.
- Undefined: no reload register; the block behaves as specified above.

Decomposition:
- Package countdown_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} cd_state_t
  - localparam DIGIT_W=4
  - localparam DEFAULT_MODULI=16'h6A6A
  - function clamp_digit(value, modulus)
- Sub-module countdown_digit, generated NUM_DIGITS times:
  - Parameter MOD; ports clk, resetN, step, loadN, din, q, is_zero.
  - Wraps 0 -> MOD-1 on step.
  - Top level forms step_i = run_tick & (all lower is_zero).

Test Plan:
- Load 16'h0102, start, 2 ticks -> count 16'h0100; 1 more tick -> 16'h0059; after 62 ticks total -> 16'h0000, expired high 1 clk, state DONE, running=0.
- Load 16'h7F9C -> count 16'h5959; load 16'h0000 then start -> stays IDLE, running=0, no expired.
- Load 16'h0010, start, 3 ticks -> 16'h0007; pause, 5 ticks -> still 16'h0007; start, 1 tick -> 16'h0006; pause+start same cycle in RUN -> PAUSE.
- RUN at 16'h0005; resetN low mid-cycle -> count 0, IDLE, expired never asserted. Then loadN low concurrent with tick and start -> count=datain, IDLE.
- Start coincident with tick at 16'h0003 -> count stays 16'h0003 that cycle, running=1 next clk.
- With COUNTDOWN_AUTORELOAD_EN: load 16'h0002, start, 2 ticks -> expired 1 clk, count 16'h0002, running still 1.

Source files
------------

// File: rtl/countdown_pkg.sv
// rtl/countdown_pkg.sv - shared types, constants and helpers for the countdown timer chain
// Purpose: run-control state encoding, digit width, default per-digit moduli and the
//          load clamping helper used by the digit and top modules.
// Ports:   none (package).
package countdown_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} cd_state_t;

  localparam int DIGIT_W = 4;

  // digit0=10, digit1=6, digit2=10, digit3=6 -> MM:SS
  localparam logic [15:0] DEFAULT_MODULI = 16'h6A6A;

  // Out-of-range load digits saturate to the largest legal value of that digit.
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] value,
                                                     input logic [DIGIT_W-1:0] modulus);
    if (value >= modulus) begin
      return modulus - 4'd1;
    end
    return value;
  endfunction

endpackage

// File: rtl/countdown_digit.sv
// rtl/countdown_digit.sv - one BCD down-counting digit with its own modulus
// Purpose: holds one digit of the countdown; loads a clamped value, steps down by one
//          and wraps 0 -> MOD-1.
// Ports:   clk, resetN (async active-low), step (decrement this cycle),
//          loadN (sync active-low load, wins over step), din (raw load digit),
//          q (current digit), is_zero (q == 0).
module countdown_digit
  import countdown_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MOD = 4'd10
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               step,
  input  logic               loadN,
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] q,
  output logic               is_zero
);

  localparam logic [DIGIT_W-1:0] MAX_V = MOD - 4'd1;

  logic [DIGIT_W-1:0] q_q;
  logic [DIGIT_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (!loadN) begin
      q_d = clamp_digit(din, MOD);
    end else if (step) begin
      q_d = (q_q == '0) ? MAX_V : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q       = q_q;
  assign is_zero = (q_q == '0);

endmodule

// File: rtl/countdown_timer_chain.sv
// rtl/countdown_timer_chain.sv - multi-digit BCD countdown timer with run control
// Purpose: chain of NUM_DIGITS BCD digits counting down on tick while running, with an
//          IDLE/RUN/PAUSE/DONE control FSM, load clamping and a one-clk expiry pulse.
//          Optional macro COUNTDOWN_AUTORELOAD_EN adds a reload register restarting the
//          count on expiry.
// Ports:   clk, resetN (async active-low), tick (count strobe), start (start/resume pulse),
//          pause (pause pulse), loadN (sync active-low load), datain (BCD load value),
//          count (BCD value), running (state==RUN, registered), expired (registered
//          one-clk pulse on reaching zero), zero (combinational, count == 0).
module countdown_timer_chain
  import countdown_pkg::*;
#(
  parameter int                            NUM_DIGITS = 4,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] MODULI     = DEFAULT_MODULI
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic                          tick,
  input  logic                          start,
  input  logic                          pause,
  input  logic                          loadN,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] datain,
  output logic [NUM_DIGITS*DIGIT_W-1:0] count,
  output logic                          running,
  output logic                          expired,
  output logic                          zero
);

  localparam int W = NUM_DIGITS * DIGIT_W;

  cd_state_t state_q, state_d;
  logic      running_q, running_d;
  logic      expired_q, expired_d;

  logic [NUM_DIGITS-1:0] is_zero;
  logic [NUM_DIGITS:0]   lower_zero;
  logic [W-1:0]          count_w;
  logic [W-1:0]          din_sel;
  logic                  digit_loadN;
  logic                  run_tick;
  logic                  will_zero;
  logic                  reload_now;

  // A decrement only happens in RUN with no higher-priority control this cycle.
  assign run_tick = (state_q == RUN) && tick && !pause && loadN;

  // The decrement lands on zero exactly when the count currently reads 1.
  assign will_zero = (count_w[DIGIT_W-1:0] == 4'd1) && (&is_zero[NUM_DIGITS-1:1]);

`ifdef COUNTDOWN_AUTORELOAD_EN
  logic [W-1:0] datain_clamped;
  logic [W-1:0] reload_q;

  for (genvar c = 0; c < NUM_DIGITS; c++) begin : g_clamp
    assign datain_clamped[c*DIGIT_W +: DIGIT_W] =
      clamp_digit(datain[c*DIGIT_W +: DIGIT_W], MODULI[c*DIGIT_W +: DIGIT_W]);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      reload_q <= '0;
    end else if (!loadN) begin
      reload_q <= datain_clamped;
    end
  end

  // A zero reload value means there is nothing to restart; fall back to DONE.
  assign reload_now  = run_tick && will_zero && (reload_q != '0);
  assign din_sel     = loadN ? reload_q : datain;
`else
  assign reload_now  = 1'b0;
  assign din_sel     = datain;
`endif

  // The reload reuses the digits' load path, so the digits see it as a load.
  assign digit_loadN = loadN && !reload_now;

  assign lower_zero[0] = 1'b1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    assign lower_zero[g+1] = lower_zero[g] & is_zero[g];

    countdown_digit #(
      .MOD(MODULI[g*DIGIT_W +: DIGIT_W])
    ) u_digit (
      .clk    (clk),
      .resetN (resetN),
      .step   (run_tick & lower_zero[g]),
      .loadN  (digit_loadN),
      .din    (din_sel[g*DIGIT_W +: DIGIT_W]),
      .q      (count_w[g*DIGIT_W +: DIGIT_W]),
      .is_zero(is_zero[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    expired_d = 1'b0;
    if (!loadN) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!pause && start && !lower_zero[NUM_DIGITS]) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (run_tick && will_zero) begin
            expired_d = 1'b1;
            state_d   = reload_now ? RUN : DONE;
          end
        end
        PAUSE: begin
          if (!pause && start) begin
            state_d = RUN;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      expired_q <= expired_d;
    end
  end

  assign count   = count_w;
  assign running = running_q;
  assign expired = expired_q;
  assign zero    = lower_zero[NUM_DIGITS];

endmodule

// File: tb/tb_countdown_timer_chain.sv
// tb/tb_countdown_timer_chain.sv - directed self-checking bench for countdown_timer_chain
module tb_countdown_timer_chain;

  logic        clk;
  logic        resetN;
  logic        tick;
  logic        start;
  logic        pause;
  logic        loadN;
  logic [15:0] datain;
  logic [15:0] count;
  logic        running;
  logic        expired;
  logic        zero;

  int checks;
  int errors;

  countdown_timer_chain dut (
    .clk    (clk),
    .resetN (resetN),
    .tick   (tick),
    .start  (start),
    .pause  (pause),
    .loadN  (loadN),
    .datain (datain),
    .count  (count),
    .running(running),
    .expired(expired),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are set before the edge and released 1 ns after it; outputs sampled then too.
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    loadN  = 1'b0;
    datain = v;
    step_clk();
    loadN  = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step_clk();
    start = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step_clk();
    end
    tick = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (count !== 16'h0000) begin
      errors++; $display("FAIL reset_count: got %h expected %h", count, 16'h0000);
    end
    checks++;
    if (running !== 1'b0 || expired !== 1'b0) begin
      errors++; $display("FAIL reset_flags: running=%b expired=%b expected 0 0", running, expired);
    end
    checks++;
    if (zero !== 1'b1) begin
      errors++; $display("FAIL reset_zero: got %b expected 1", zero);
    end
  endtask

  task automatic test_countdown();
    do_load(16'h0102);
    do_start();
    checks++;
    if (running !== 1'b1) begin
      errors++; $display("FAIL cd_running: got %b expected 1", running);
    end
    do_ticks(2);
    checks++;
    if (count !== 16'h0100) begin
      errors++; $display("FAIL cd_2ticks: got %h expected %h", count, 16'h0100);
    end
    do_ticks(1);
    checks++;
    if (count !== 16'h0059) begin
      errors++; $display("FAIL cd_borrow: got %h expected %h", count, 16'h0059);
    end
    do_ticks(58);
    checks++;
    if (count !== 16'h0001 || expired !== 1'b0) begin
      errors++; $display("FAIL cd_61ticks: count=%h expired=%b expected 0001 0", count, expired);
    end
    do_ticks(1);
    checks++;
    if (count !== 16'h0000 || expired !== 1'b1 || running !== 1'b0 || zero !== 1'b1) begin
      errors++; $display("FAIL cd_expire: count=%h expired=%b running=%b zero=%b expected 0000 1 0 1",
                         count, expired, running, zero);
    end
    step_clk();
    checks++;
    if (expired !== 1'b0) begin
      errors++; $display("FAIL cd_expire_width: got %b expected 0", expired);
    end
    do_start();
    do_ticks(2);
    checks++;
    if (running !== 1'b0 || count !== 16'h0000 || expired !== 1'b0) begin
      errors++; $display("FAIL cd_done_hold: running=%b count=%h expired=%b expected 0 0000 0",
                         running, count, expired);
    end
  endtask

  task automatic test_clamp();
    do_load(16'h7F9C);
    checks++;
    if (count !== 16'h5959) begin
      errors++; $display("FAIL clamp: got %h expected %h", count, 16'h5959);
    end
    do_load(16'h0000);
    do_start();
    do_ticks(1);
    checks++;
    if (running !== 1'b0 || expired !== 1'b0 || count !== 16'h0000) begin
      errors++; $display("FAIL start_at_zero: running=%b expired=%b count=%h expected 0 0 0000",
                         running, expired, count);
    end
  endtask

  task automatic test_pause();
    do_load(16'h0010);
    do_start();
    do_ticks(3);
    checks++;
    if (count !== 16'h0007) begin
      errors++; $display("FAIL pause_pre: got %h expected %h", count, 16'h0007);
    end
    pause = 1'b1;
    step_clk();
    pause = 1'b0;
    do_ticks(5);
    checks++;
    if (count !== 16'h0007 || running !== 1'b0) begin
      errors++; $display("FAIL pause_hold: count=%h running=%b expected 0007 0", count, running);
    end
    do_start();
    do_ticks(1);
    checks++;
    if (count !== 16'h0006 || running !== 1'b1) begin
      errors++; $display("FAIL resume: count=%h running=%b expected 0006 1", count, running);
    end
    pause = 1'b1;
    start = 1'b1;
    tick  = 1'b1;
    step_clk();
    pause = 1'b0;
    start = 1'b0;
    tick  = 1'b0;
    checks++;
    if (running !== 1'b0 || count !== 16'h0006) begin
      errors++; $display("FAIL pause_wins: running=%b count=%h expected 0 0006", running, count);
    end
  endtask

  task automatic test_async_reset();
    int seen_expired;
    seen_expired = 0;
    do_load(16'h0005);
    do_start();
    do_ticks(1);
    #2;
    resetN = 1'b0;
    #1;
    checks++;
    if (count !== 16'h0000 || running !== 1'b0) begin
      errors++; $display("FAIL async_reset: count=%h running=%b expected 0000 0", count, running);
    end
    @(negedge clk);
    resetN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick = 1'b1;
      step_clk();
      if (expired !== 1'b0) seen_expired++;
    end
    tick = 1'b0;
    checks++;
    if (seen_expired != 0 || count !== 16'h0000) begin
      errors++; $display("FAIL reset_no_expire: expired_cycles=%0d count=%h expected 0 0000",
                         seen_expired, count);
    end
    do_load(16'h0005);
    do_start();
    loadN  = 1'b0;
    datain = 16'h0042;
    tick   = 1'b1;
    start  = 1'b1;
    step_clk();
    loadN  = 1'b1;
    start  = 1'b0;
    checks++;
    if (count !== 16'h0042 || running !== 1'b0) begin
      errors++; $display("FAIL load_priority: count=%h running=%b expected 0042 0", count, running);
    end
    step_clk();
    tick = 1'b0;
    checks++;
    if (count !== 16'h0042) begin
      errors++; $display("FAIL load_idle_tick: got %h expected %h", count, 16'h0042);
    end
  endtask

  task automatic test_start_tick();
    do_load(16'h0003);
    start = 1'b1;
    tick  = 1'b1;
    step_clk();
    start = 1'b0;
    tick  = 1'b0;
    checks++;
    if (count !== 16'h0003 || running !== 1'b1) begin
      errors++; $display("FAIL start_tick: count=%h running=%b expected 0003 1", count, running);
    end
    do_ticks(1);
    checks++;
    if (count !== 16'h0002) begin
      errors++; $display("FAIL start_tick_next: got %h expected %h", count, 16'h0002);
    end
  endtask

  task automatic test_autoreload();
    do_load(16'h0002);
    do_start();
    do_ticks(1);
    checks++;
    if (count !== 16'h0001 || expired !== 1'b0) begin
      errors++; $display("FAIL ar_first: count=%h expired=%b expected 0001 0", count, expired);
    end
    do_ticks(1);
`ifdef COUNTDOWN_AUTORELOAD_EN
    checks++;
    if (count !== 16'h0002 || expired !== 1'b1 || running !== 1'b1) begin
      errors++; $display("FAIL ar_reload: count=%h expired=%b running=%b expected 0002 1 1",
                         count, expired, running);
    end
`else
    checks++;
    if (count !== 16'h0000 || expired !== 1'b1 || running !== 1'b0) begin
      errors++; $display("FAIL ar_plain: count=%h expired=%b running=%b expected 0000 1 0",
                         count, expired, running);
    end
`endif
    step_clk();
    checks++;
    if (expired !== 1'b0) begin
      errors++; $display("FAIL ar_pulse_width: got %b expected 0", expired);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetN = 1'b0;
    tick   = 1'b0;
    start  = 1'b0;
    pause  = 1'b0;
    loadN  = 1'b1;
    datain = 16'h0000;
    #12;
    test_reset();
    resetN = 1'b1;
    @(negedge clk);
    test_countdown();
    test_clamp();
    test_pause();
    test_async_reset();
    test_start_tick();
    test_autoreload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
